// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART transmit line between NUM_REQ requesters.
// Bit timing is driven by an external baud_tick enable; each bit lasts OVERSAMPLE ticks.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ID_W       = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           baud_tick,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx,
  output logic                           busy,
  output logic [ID_W-1:0]                grant_id
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_n;
  logic [TICK_W-1:0]      tick_cnt, tick_n;
  logic [BIT_W-1:0]       bit_cnt, bit_n;
  logic [DATA_BITS-1:0]   shift_reg, shift_n;
  logic [ID_W-1:0]        rr_ptr, rr_n, grant_n;
  logic                   tx_n, busy_n;
  logic                   live;

  logic [DATA_BITS-1:0]   lane [NUM_REQ];
  logic                   found_hi, found_lo, found;
  logic [ID_W-1:0]        win_hi, win_lo, win;
  logic [DATA_BITS-1:0]   data_hi, data_lo, win_data;
  logic                   bit_end;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = req_data[i*DATA_BITS +: DATA_BITS];
  end

  // Round-robin pick: lowest valid index at or above rr_ptr, else wrap to lowest valid.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    data_hi  = '0;
    data_lo  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = ID_W'(i);
        data_lo  = lane[i];
      end
      if (req_valid[i] && !found_hi && (ID_W'(i) >= rr_ptr)) begin
        found_hi = 1'b1;
        win_hi   = ID_W'(i);
        data_hi  = lane[i];
      end
    end
    found    = found_lo;
    win      = found_hi ? win_hi : win_lo;
    win_data = found_hi ? data_hi : data_lo;
  end

  // Accept pulse; 'live' keeps it low while reset is held.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = live && (state == IDLE) && found && (win == ID_W'(i));
    end
  end

  assign bit_end = baud_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    rr_n    = rr_ptr;
    grant_n = grant_id;

    if (state != IDLE && baud_tick) begin
      tick_n = bit_end ? '0 : tick_cnt + TICK_W'(1);
    end

    case (state)
      IDLE: begin
        if (live && found) begin
          state_n = START;
          shift_n = win_data;
          grant_n = win;
          rr_n    = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
          tick_n  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift_reg >> 1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            state_n = STOP;
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rr_ptr    <= '0;
      grant_id  <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      live      <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      rr_ptr    <= rr_n;
      grant_id  <= grant_n;
      tx        <= tx_n;
      busy      <= busy_n;
      live      <= 1'b1;
    end
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART transmit line between NUM_REQ requesters using round-robin arbitration.
Each accepted byte is serialised as 8N1 framing: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit.
Bit timing comes from an external baud_tick enable, which pulses one clk cycle every 27 clocks; each bit lasts OVERSAMPLE ticks.
Sits between the CPU-side UART/debug sources and the baud generator.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_BITS, 8, data bits per frame
OVERSAMPLE, 16, baud_tick pulses per serial bit
ID_W, 2, width of grant_id; must be >= clog2(NUM_REQ)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
baud_tick  input  1  single-cycle bit-timing enable
req_valid  input  NUM_REQ  requester i has a byte; held until accepted
req_data  input  NUM_REQ*DATA_BITS  byte of requester i at bits [i*DATA_BITS +: DATA_BITS]
req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse; byte transferred when valid&ready
tx  output  1  serial line, idle high
busy  output  1  high from the cycle after acceptance through the end of the stop bit
grant_id  output  ID_W  index of the requester currently being served; holds last value when idle

Behaviour:
- Reset, asynchronous: state=IDLE, tx=1, busy=0, req_ready=0, grant_id=0, rr_ptr=0, tick_cnt=0, bit_cnt=0.
- Reset is asserted by the codebase convention: clk and reset_n, async active-low.
- States: IDLE, START, DATA, STOP.
- IDLE, arbitration:
  - If any req_valid is set, search i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first valid index g wins.
  - Same cycle: req_ready[g]=1 (combinational from registered state), data latched into shift_reg, grant_id<=g, rr_ptr<=(g+1) mod NUM_REQ, tick_cnt<=0, next state START.
  - req_ready is asserted only in IDLE and never for more than one bit.
  - No valid input: stay in IDLE, tx=1; baud_tick is ignored.
- START: tx=0.
- DATA: tx=shift_reg[0].
- STOP: tx=1.
- Bit advance (START, DATA, STOP):
  - On baud_tick, if tick_cnt==OVERSAMPLE-1, then tick_cnt<=0 and the bit ends; otherwise tick_cnt++.
  - No baud_tick: hold.
- Transitions:
  - START end -> DATA, bit_cnt=0.
  - DATA end -> shift right; bit_cnt++; when bit_cnt==DATA_BITS-1, go to STOP.
  - STOP end -> IDLE, busy=0.
- Latency: tx falls the cycle after acceptance.
  - The first bit may be up to one tick period longer, due to phase alignment with baud_tick.
  - Every later bit is exactly OVERSAMPLE ticks.
- Back-to-back frames: the earliest next acceptance is the first IDLE cycle after STOP ends.
  - The minimum idle gap is 1 clk.
- req_valid or req_data changing after acceptance has no effect on the frame in flight.
- A requester deasserting valid before it is granted is simply skipped.
- tx is a registered output: no glitches, no combinational path from req_*.
- Reset mid-frame: tx returns to 1 immediately and the frame is aborted.
  - The byte is not retried; the requester already saw ready.
  - rr_ptr returns to 0.

Test Plan:
1. Single request, 0x55 on req 0, baud_tick every 27 clk:
   - req_ready[0] pulses once.
   - tx sequence is 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop).
   - Data and stop bits are each 432 clk.
   - busy falls after 10 bits; grant_id=0.
2. All four requesters valid simultaneously and held, data 0xA0..0xA3:
   - Grants occur in order 0,1,2,3,0.
   - Frames carry 0xA0, 0xA1, 0xA2, 0xA3.
   - Each req_ready is exactly one pulse per frame.
3. Fairness: after a grant to 2, requesters 1 and 3 are valid:
   - Requester 3 is served next, then 1.
   - rr_ptr wraps 3->0->1 correctly.
4. baud_tick held constantly high:
   - Every bit lasts exactly 16 clk.
   - A full frame spans 160 clk plus up to 1 clk of latency.
5. reset_n pulsed low during data bit 3 of a frame:
   - tx=1 and busy=0 immediately, asynchronously.
   - After release, with reqs 1 and 2 valid, requester 1 is granted (rr_ptr=0 search).
6. baud_tick absent for 1000 clk mid-frame:
   - State, tx and tick_cnt hold.
   - The frame resumes with the bit width unchanged.
